// File: rtl/mult_unit_if.sv
// Request/response bundle between the execution stage and the HI/LO multiplier.
interface mult_unit_if #(
  parameter int DATA_W = 32
);
  logic              mult_start;
  logic [DATA_W-1:0] mult_opr1;
  logic [DATA_W-1:0] mult_opr2;
  logic              mult_unsigned;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] hi_wdata;
  logic [DATA_W-1:0] lo_wdata;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              busy;
  logic              done;

  modport master (
    output mult_start, mult_opr1, mult_opr2, mult_unsigned,
    output hi_we, lo_we, hi_wdata, lo_wdata,
    input  hi, lo, busy, done
  );

  modport slave (
    input  mult_start, mult_opr1, mult_opr2, mult_unsigned,
    input  hi_we, lo_we, hi_wdata, lo_wdata,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU owning the HI/LO registers.
// Signed operands are multiplied as magnitudes and the product sign is applied at the end.
module mult_unit #(
  parameter int DATA_W = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mult_unit_if.slave bus
);
  localparam int CNT_W  = $clog2(DATA_W) + 1;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [PROD_W-1:0]   acc_q;
  logic [DATA_W-1:0]   hi_q, lo_q;
  logic                done_q;

  logic [DATA_W-1:0]   mcand_q, mplier_q;
  logic                uns_q, sign_q;

  logic                accept, step, fix, last_step;
  logic [PROD_W-1:0]   addend;
  logic [PROD_W-1:0]   product;

  // Magnitude of a two's complement value; the most negative value maps to itself as unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] u;
    u = x;
    return (x < 0) ? (~u + DATA_W'(1)) : u;
  endfunction

  function automatic logic [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] p, input logic neg);
    return neg ? (~p + PROD_W'(1)) : p;
  endfunction

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    step      = 1'b0;
    fix       = 1'b0;
    last_step = (cnt_q == CNT_W'(DATA_W - 1));
    unique case (state_q)
      IDLE: begin
        if (bus.mult_start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last_step) state_d = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign addend  = mplier_q[cnt_q[CNT_W-2:0]] ? ({{DATA_W{1'b0}}, mcand_q} << cnt_q) : '0;
  assign product = apply_sign(acc_q, sign_q & ~uns_q);

  // Control state, accumulator and architectural HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= fix;
      if (accept) begin
        cnt_q <= '0;
        acc_q <= '0;
      end else if (step) begin
        cnt_q <= cnt_q + CNT_W'(1);
        acc_q <= acc_q + addend;
      end
      // A finishing product takes priority over a coincident MTHI/MTLO.
      if (fix) begin
        {hi_q, lo_q} <= product;
      end else begin
        if (bus.hi_we) hi_q <= bus.hi_wdata;
        if (bus.lo_we) lo_q <= bus.lo_wdata;
      end
    end
  end

  // Operand capture at the accepting edge
  always_ff @(posedge clk) begin
    if (accept) begin
      uns_q    <= bus.mult_unsigned;
      sign_q   <= bus.mult_opr1[DATA_W-1] ^ bus.mult_opr2[DATA_W-1];
      mcand_q  <= bus.mult_unsigned ? bus.mult_opr1 : magnitude(bus.mult_opr1);
      mplier_q <= bus.mult_unsigned ? bus.mult_opr2 : magnitude(bus.mult_opr2);
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
endmodule
